// File: rtl/ncl_pkg.sv
// rtl/ncl_pkg.sv - dual-rail encodings and TH22/completion helper functions
package ncl_pkg;

  // Each encoding is {t-rail, f-rail}.
  localparam logic [1:0] DR_NULL    = 2'b00;
  localparam logic [1:0] DR_ZERO    = 2'b01;
  localparam logic [1:0] DR_ONE     = 2'b10;
  localparam logic [1:0] DR_ILLEGAL = 2'b11;

  // Widest word the completion classifier accepts.
  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    CMP_PARTIAL = 2'd0,
    CMP_DATA    = 2'd1,
    CMP_NULL    = 2'd2
  } cmp_e;

  function automatic logic th22_next(input logic a, input logic b, input logic y);
    return (a & b) | (y & (a | b));
  endfunction

  // Only the low w bits are classified; the rest of each vector is ignored.
  function automatic cmp_e thnn_complete(input logic [MAX_W-1:0] t,
                                         input logic [MAX_W-1:0] f,
                                         input int w);
    logic all_data;
    logic all_null;
    all_data = 1'b1;
    all_null = 1'b1;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w) begin
        all_data = all_data & (t[i] ^ f[i]);
        all_null = all_null & ~(t[i] | f[i]);
      end
    end
    if (all_null)
      return CMP_NULL;
    else if (all_data)
      return CMP_DATA;
    else
      return CMP_PARTIAL;
  endfunction

endpackage

// File: rtl/ncl_completion.sv
// rtl/ncl_completion.sv - hysteretic completion detector owning the ko register
module ncl_completion
  import ncl_pkg::*;
#(
  parameter int   W        = 8,
  parameter logic RESET_KO = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] q_t,
  input  logic [W-1:0] q_f,
  output logic         ko,
  output logic         ko_fall
);

  cmp_e cls;

  assign cls = thnn_complete(MAX_W'(q_t), MAX_W'(q_f), W);

  // ko falls on this edge: the stage has just latched a full DATA wavefront.
  assign ko_fall = ko & (cls == CMP_DATA);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ko <= RESET_KO;
    end else begin
      unique case (cls)
        CMP_DATA: ko <= 1'b0;
        CMP_NULL: ko <= 1'b1;
        default:  ko <= ko;
      endcase
    end
  end

endmodule

// File: rtl/ncl_th22_reg.sv
// rtl/ncl_th22_reg.sv - W-bit NCL dual-rail TH22 register stage with handshake
module ncl_th22_reg
  import ncl_pkg::*;
#(
  parameter int W          = 8,
  parameter int RESET_DATA = 0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     d_t,
  input  logic [W-1:0]     d_f,
  input  logic             ki,
  output logic [W-1:0]     q_t,
  output logic [W-1:0]     q_f,
  output logic             ko,
  output logic             err,
  output logic [CNT_W-1:0] wave_cnt
);

  logic [W-1:0] t_nxt;
  logic [W-1:0] f_nxt;
  logic         illegal;
  logic         ko_fall;

  always_comb begin
    t_nxt   = '0;
    f_nxt   = '0;
    illegal = 1'b0;
    for (int i = 0; i < W; i++) begin
      t_nxt[i] = th22_next(d_t[i], ki, q_t[i]);
      f_nxt[i] = th22_next(d_f[i], ki, q_f[i]);
      if ({d_t[i], d_f[i]} == DR_ILLEGAL || {q_t[i], q_f[i]} == DR_ILLEGAL)
        illegal = 1'b1;
    end
  end

  // RESET_DATA=1 parks the stage on DATA0, so ko must start at rfn.
  ncl_completion #(
    .W        (W),
    .RESET_KO (RESET_DATA == 0)
  ) u_completion (
    .clk     (clk),
    .rst_n   (rst_n),
    .q_t     (q_t),
    .q_f     (q_f),
    .ko      (ko),
    .ko_fall (ko_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_t      <= '0;
      q_f      <= (RESET_DATA != 0) ? {W{1'b1}} : '0;
      err      <= 1'b0;
      wave_cnt <= '0;
    end else begin
      q_t <= t_nxt;
      q_f <= f_nxt;
      if (illegal)
        err <= 1'b1;
      if (ko_fall)
        wave_cnt <= wave_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ncl_th22_reg.sv
// tb/tb_ncl_th22_reg.sv - scoreboard bench for ncl_th22_reg, both reset wavefronts
module tb_ncl_th22_reg;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] d_t = '0;
  logic [3:0] d_f = '0;
  logic       ki = 1'b0;

  logic [3:0] q_t0, q_f0, cnt0;
  logic       ko0, err0;
  logic [3:0] q_t1, q_f1, cnt1;
  logic       ko1, err1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] qt;
    logic [3:0] qf;
    logic       ko;
    logic       err;
    logic [3:0] cnt;
  } exp_t;

  exp_t sbq[$];

  logic [3:0] m_qt[2];
  logic [3:0] m_qf[2];
  logic       m_ko[2];
  logic       m_err[2];
  logic [3:0] m_cnt[2];

  always #5 clk = ~clk;

  ncl_th22_reg #(.W(4), .RESET_DATA(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .d_t(d_t), .d_f(d_f), .ki(ki),
    .q_t(q_t0), .q_f(q_f0), .ko(ko0), .err(err0), .wave_cnt(cnt0)
  );

  ncl_th22_reg #(.W(4), .RESET_DATA(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .d_t(d_t), .d_f(d_f), .ki(ki),
    .q_t(q_t1), .q_f(q_f1), .ko(ko1), .err(err1), .wave_cnt(cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected state after the coming edge (or immediately, while reset is low).
  task automatic model_eval(input int k);
    exp_t e;
    logic cd, an;
    if (!rst_n) begin
      m_qt[k]  = 4'h0;
      m_qf[k]  = (k == 1) ? 4'hF : 4'h0;
      m_ko[k]  = (k == 0);
      m_err[k] = 1'b0;
      m_cnt[k] = 4'h0;
    end else begin
      cd = 1'b1;
      an = 1'b1;
      for (int i = 0; i < 4; i++) begin
        cd = cd & (m_qt[k][i] != m_qf[k][i]);
        an = an & !m_qt[k][i] & !m_qf[k][i];
      end
      m_err[k] = m_err[k] | (|(d_t & d_f)) | (|(m_qt[k] & m_qf[k]));
      if (m_ko[k] && cd)
        m_cnt[k] = 4'(m_cnt[k] + 4'd1);
      if (cd)
        m_ko[k] = 1'b0;
      else if (an)
        m_ko[k] = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (d_t[i] == ki) m_qt[k][i] = ki;
        if (d_f[i] == ki) m_qf[k][i] = ki;
      end
    end
    e.qt = m_qt[k]; e.qf = m_qf[k]; e.ko = m_ko[k]; e.err = m_err[k]; e.cnt = m_cnt[k];
    sbq.push_back(e);
  endtask

  task automatic compare_pop(input int k);
    exp_t e;
    if (sbq.size() == 0) begin
      chk("sb_empty", 32'(sbq.size()), 32'd1);
      return;
    end
    e = sbq.pop_front();
    chk($sformatf("q_t%0d", k), 32'(k ? q_t1 : q_t0), 32'(e.qt));
    chk($sformatf("q_f%0d", k), 32'(k ? q_f1 : q_f0), 32'(e.qf));
    chk($sformatf("ko%0d", k),  32'(k ? ko1 : ko0),   32'(e.ko));
    chk($sformatf("err%0d", k), 32'(k ? err1 : err0), 32'(e.err));
    chk($sformatf("cnt%0d", k), 32'(k ? cnt1 : cnt0), 32'(e.cnt));
  endtask

  task automatic step();
    model_eval(0);
    model_eval(1);
    @(posedge clk);
    #1;
    compare_pop(0);
    compare_pop(1);
  endtask

  // Called from posedge+1, so reset falls mid-cycle and is checked before any edge.
  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    model_eval(0);
    model_eval(1);
    compare_pop(0);
    compare_pop(1);
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  task automatic drive(input logic k, input logic [3:0] t, input logic [3:0] f);
    ki = k;
    d_t = t;
    d_f = f;
  endtask

  initial begin
    logic [3:0] r;
    @(posedge clk);
    #1;
    apply_reset();
    chk("rst_ko0", 32'(ko0), 32'd1);
    chk("rst_qf1", 32'(q_f1), 32'hF);
    chk("rst_ko1", 32'(ko1), 32'd0);

    // Data presented while ki=0 must not be latched.
    drive(1'b0, 4'b1010, 4'b0101);
    repeat (2) step();
    chk("rfn_hold_qt0", 32'(q_t0), 32'h0);

    drive(1'b1, 4'b1010, 4'b0101);
    step();
    chk("s1_qt0", 32'(q_t0), 32'hA);
    chk("s1_qf0", 32'(q_f0), 32'h5);
    step();
    chk("s1_ko0", 32'(ko0), 32'd0);
    chk("s1_cnt0", 32'(cnt0), 32'd1);

    drive(1'b1, 4'b0000, 4'b0000);
    repeat (2) step();
    chk("s2_hold_qt0", 32'(q_t0), 32'hA);
    drive(1'b0, 4'b0000, 4'b0000);
    step();
    chk("s2_null_qt0", 32'(q_t0), 32'h0);
    step();
    chk("s2_ko0", 32'(ko0), 32'd1);

    drive(1'b1, 4'b0011, 4'b0100);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("s3_partial_ko0", 32'(ko0), 32'd1);
    end
    drive(1'b1, 4'b0011, 4'b1100);
    repeat (2) step();
    chk("s3_ko0", 32'(ko0), 32'd0);
    drive(1'b0, 4'b0000, 4'b0000);
    repeat (2) step();

    drive(1'b1, 4'b0100, 4'b0100);
    step();
    chk("s4_err0", 32'(err0), 32'd1);
    drive(1'b1, 4'b0000, 4'b0100);
    repeat (2) step();
    chk("s4_sticky0", 32'(err0), 32'd1);
    drive(1'b0, 4'b0000, 4'b0000);
    repeat (2) step();
    apply_reset();
    chk("s4_clr0", 32'(err0), 32'd0);

    for (int n = 0; n < 17; n++) begin
      r = 4'($urandom_range(0, 15));
      drive(1'b1, r, ~r);
      repeat (2) step();
      drive(1'b0, 4'b0000, 4'b0000);
      repeat (2) step();
    end
    chk("s5_wrap0", 32'(cnt0), 32'd1);

    apply_reset();
    chk("s6_qf1", 32'(q_f1), 32'hF);
    chk("s6_ko1", 32'(ko1), 32'd0);
    drive(1'b1, 4'b0011, 4'b0000);
    step();
    apply_reset();
    chk("s6_mid_qt1", 32'(q_t1), 32'h0);
    chk("s6_mid_cnt1", 32'(cnt1), 32'd0);
    drive(1'b0, 4'b0000, 4'b0000);
    repeat (2) step();
    chk("s6_ko1", 32'(ko1), 32'd1);
    chk("s6_cnt1", 32'(cnt1), 32'd0);
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
